// File: rtl/ula_mul_seq.sv
// Sequential unsigned W x W shift-and-add multiplier that borrows the ULA's shared ripple adder.
// One adder pass per multiplier bit, then a one-cycle done pulse; product {ACC,Q} holds afterwards.
module ula_mul_seq #(
    parameter int unsigned W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [W-1:0]     o_add_a,
    output logic [W-1:0]     o_add_b,
    input  logic [W:0]       i_add_s,
    output logic             o_busy,
    output logic             o_done,
    output logic [2*W-1:0]   o_p
);

    localparam int unsigned CntW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_t;

    state_t          r_state, w_state_d;
    logic [W-1:0]    r_m, r_acc, r_q;
    logic [W-1:0]    w_m_d, w_acc_d, w_q_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_m     <= w_m_d;
            r_acc   <= w_acc_d;
            r_q     <= w_q_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_m_d     = r_m;
        w_acc_d   = r_acc;
        w_q_d     = r_q;
        w_cnt_d   = r_cnt;
        o_add_a   = '0;
        o_add_b   = '0;
        o_busy    = 1'b0;
        o_done    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_m_d     = i_a;
                    w_q_d     = i_b;
                    w_acc_d   = '0;
                    w_cnt_d   = CntW'(W);
                    w_state_d = StCalc;
                end
            end
            StCalc: begin
                o_busy  = 1'b1;
                o_add_a = r_acc;
                o_add_b = r_q[0] ? r_m : '0;
                // Shift {carry,sum,Q} right by one so the adder carry-out lands in ACC's MSB.
                w_acc_d = i_add_s[W:1];
                w_q_d   = {i_add_s[0], r_q[W-1:1]};
                w_cnt_d = r_cnt - CntW'(1);
                if (r_cnt == CntW'(1)) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                o_busy    = 1'b1;
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_p = {r_acc, r_q};

endmodule

// File: tb/tb_ula_mul_seq.sv
// Self-checking bench for ula_mul_seq: external adder model plus a plain a*b reference.
`timescale 1ns/1ps
module tb_ula_mul_seq;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a, b;
    logic [W-1:0]  add_a, add_b;
    logic [W:0]    add_s;
    logic          busy, done;
    logic [2*W-1:0] p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared ripple adder, modelled behaviourally.
    assign add_s = {1'b0, add_a} + {1'b0, add_b};

    ula_mul_seq #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_add_a (add_a),
        .o_add_b (add_b),
        .i_add_s (add_s),
        .o_busy  (busy),
        .o_done  (done),
        .o_p     (p)
    );

    // Drives one multiply; lat counts edges from the accepting edge through the edge raising done.
    task automatic do_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_v, output int lat,
                          output int nbusy, output logic [2*W-1:0] prod, output logic quiet);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge clk);
        lat   = -1;
        nbusy = 0;
        prod  = '0;
        quiet = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            if (busy) nbusy++;
            if (done) begin
                prod  = p;
                quiet = (add_a == '0) && (add_b == '0);
                lat   = k + 1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (p !== '0) begin errors++; $display("FAIL reset_p got %0h want 0", p); end
        checks++; if (add_a !== '0 || add_b !== '0) begin
            errors++; $display("FAIL reset_adder got a=%0h b=%0h want 0 0", add_a, add_b);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || p !== '0) begin
            errors++; $display("FAIL idle_after_reset got busy=%0b p=%0h want 0 0", busy, p);
        end
    endtask

    task automatic test_basic();
        int lat, nb; logic [2*W-1:0] pr; logic q;
        do_mul(8'd13, 8'd11, lat, nb, pr, q);
        checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
        checks++; if (pr !== 16'd143) begin errors++; $display("FAIL basic_p got %0d want 143", pr); end
        checks++; if (nb !== 9) begin errors++; $display("FAIL basic_busy_cycles got %0d want 9", nb); end
        checks++; if (q !== 1'b1) begin errors++; $display("FAIL basic_done_adder_quiet got %0b want 1", q); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_back_idle got busy=%0b done=%0b want 0 0", busy, done);
        end
        checks++; if (p !== 16'd143) begin errors++; $display("FAIL basic_p_hold got %0d want 143", p); end
    endtask

    task automatic test_max();
        int lat, nb; logic [2*W-1:0] pr; logic q;
        do_mul(8'd255, 8'd255, lat, nb, pr, q);
        checks++; if (pr !== 16'hFE01) begin errors++; $display("FAIL max_p got %0h want fe01", pr); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL max_latency got %0d want 9", lat); end
    endtask

    task automatic test_zero();
        int lat, nb; logic [2*W-1:0] pr; logic q;
        do_mul(8'd0, 8'd200, lat, nb, pr, q);
        checks++; if (pr !== '0) begin errors++; $display("FAIL zero_a_p got %0d want 0", pr); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL zero_a_latency got %0d want 9", lat); end
        do_mul(8'd200, 8'd0, lat, nb, pr, q);
        checks++; if (pr !== '0) begin errors++; $display("FAIL zero_b_p got %0d want 0", pr); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL zero_b_latency got %0d want 9", lat); end
    endtask

    task automatic test_random();
        int lat, nb; logic [2*W-1:0] pr; logic q;
        logic [W-1:0] ra, rb; int expv;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            expv = int'(ra) * int'(rb);
            do_mul(ra, rb, lat, nb, pr, q);
            checks++; if (int'(pr) !== expv) begin
                errors++; $display("FAIL random_p %0d*%0d got %0d want %0d", ra, rb, pr, expv);
            end
            checks++; if (lat !== 9 || nb !== 9) begin
                errors++; $display("FAIL random_timing got lat=%0d busy=%0d want 9 9", lat, nb);
            end
        end
    endtask

    task automatic test_ignored_start();
        int lat; logic [2*W-1:0] pr;
        lat = -1; pr = '0;
        @(negedge clk); start = 1'b1; a = 8'd3; b = 8'd5;
        @(posedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 3) begin start = 1'b1; a = 8'd7; b = 8'd7; end
            if (k == 4) start = 1'b0;
            if (done) begin
                pr = p; lat = k + 1;
                start = 1'b1; a = 8'd7; b = 8'd7;
                break;
            end
            @(posedge clk);
        end
        checks++; if (pr !== 16'd15) begin errors++; $display("FAIL ignore_p got %0d want 15", pr); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL ignore_latency got %0d want 9", lat); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_done_start got busy=%0b want 0", busy); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || p !== 16'd15) begin
            errors++; $display("FAIL ignore_not_queued got busy=%0b p=%0d want 0 15", busy, p);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nb, spurious; logic [2*W-1:0] pr; logic q;
        @(negedge clk); start = 1'b1; a = 8'd100; b = 8'd100;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got busy=%0b done=%0b want 0 0", busy, done);
        end
        checks++; if (p !== '0) begin errors++; $display("FAIL midrst_p got %0h want 0", p); end
        spurious = 0;
        repeat (2) begin @(negedge clk); if (done || busy) spurious++; end
        rst = 1'b0;
        repeat (12) begin @(negedge clk); if (done || busy) spurious++; end
        checks++; if (spurious !== 0) begin
            errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", spurious);
        end
        do_mul(8'd100, 8'd100, lat, nb, pr, q);
        checks++; if (pr !== 16'd10000) begin errors++; $display("FAIL midrst_rerun got %0d want 10000", pr); end
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        int bad_quiet, bad_p;
        bad_quiet = 0; bad_p = 0;
        @(negedge clk); start = 1'b1; a = 8'd2; b = 8'd9;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if ((!busy || done) && (add_a !== '0 || add_b !== '0)) bad_quiet++;
            if (done) begin
                done_cyc.push_back(c);
                if (p !== 16'd18) bad_p++;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (done_cyc.size() < 4) begin
            errors++; $display("FAIL b2b_pulses got %0d want >=4", done_cyc.size());
        end
        for (int i = 1; i < done_cyc.size(); i++) begin
            checks++; if (done_cyc[i] - done_cyc[i-1] !== 10) begin
                errors++; $display("FAIL b2b_spacing got %0d want 10", done_cyc[i] - done_cyc[i-1]);
            end
        end
        checks++; if (bad_p !== 0) begin errors++; $display("FAIL b2b_p got %0d wrong products want 0", bad_p); end
        checks++; if (bad_quiet !== 0) begin
            errors++; $display("FAIL b2b_adder_quiet got %0d noisy cycles want 0", bad_quiet);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_random();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ula_mul_seq.md
Name: ula_mul_seq

Overview:
- Sequential unsigned W x W multiplier controller for the ULA.
- Uses the shared external W-bit ripple adder, which is combinational with a (W+1)-bit sum including carry-out.
- Runs the classic shift-and-add algorithm: one adder pass per multiplier bit, then a one-cycle completion flag.
- Sits between the ULA operation decoder and the adder, so the product needs no dedicated array multiplier.

Parameters:
- W, 8, operand width. Only 8 is required and verified; the step counter is sized as clog2(W)+1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  W  multiplicand; captured on an accepted start
- b  input  W  multiplier; captured on an accepted start
- add_a  output  W  adder operand A, driven from the accumulator register ACC
- add_b  output  W  adder operand B: M when Q[0]=1, else all zeros
- add_s  input  W+1  adder sum; bit W is carry-out
- busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive
- done  output  1  one-cycle pulse; product valid
- p  output  2W  product {ACC,Q}; holds until the next accepted start or reset

Behaviour:
- Registers:
  - M (W): multiplicand
  - ACC (W): high half of the product
  - Q (W): multiplier / low half of the product
  - CNT: step counter
  - state: IDLE, CALC or DONE
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; M=ACC=Q=CNT=0
  - busy=0, done=0, p=0
  - Any operation in flight is abandoned; there is no partial result.
- IDLE:
  - busy=0, done=0.
  - When start=1 on an edge: M<=a, Q<=b, ACC<=0, CNT<=W, then go to CALC.
  - When start=0: remain in IDLE; p keeps its last value.
- CALC (exactly W cycles):
  - Per cycle: {ACC,Q} <= {add_s, Q} >> 1, i.e. ACC<=add_s[W:1], Q<={add_s[0], Q[W-1:1]}; CNT<=CNT-1.
  - add_b=0 when Q[0]=0, so the update reduces to a plain shift with a 0 carry.
  - The carry-out (add_s[W]) is never lost: it enters the MSB of ACC.
  - After the step in which CNT goes 1->0, go to DONE.
- DONE (one cycle): done=1, busy=1, p valid; next state is IDLE unconditionally.
- start handling:
  - Ignored in CALC and DONE; it is not queued.
  - A start asserted in the DONE cycle is lost. The requester must hold start or re-assert it in IDLE.
- Latency: start accepted at edge 0; CALC covers edges 1..W; done is high in the cycle after edge W.
  - Start-accepting edge to done-high cycle is W+1 edges (9 for W=8).
  - Minimum spacing between accepted starts is W+2 cycles.
- Outputs:
  - busy and done decode from state only; they are glitch-free registered state, with no input-to-output combinational path.
  - add_a and add_b depend combinationally on registers only. In IDLE and DONE both are 0, keeping the shared adder quiet.
- Arithmetic:
  - Unsigned only; the result is exact for all W x W inputs and never exceeds 2W bits.
  - 0 operands need no special case: they are processed in the full W cycles.
- a and b may change freely after the accepted start edge without affecting the result.

Test Plan:
- Reset, then start with a=13, b=11 -> done exactly 9 edges after the start edge; p=143 (0x008F); busy high for 9 cycles.
- a=255, b=255 -> p=65025 (0xFE01). This checks carry-out capture on every add step.
- a=0, b=200 and a=200, b=0 -> p=0 in both cases; latency still 9.
- Start at edge 0 (a=3, b=5), then start pulses with a=7, b=7 during CALC and in the DONE cycle -> p=15; the extra pulses are ignored; the next operation starts only from IDLE.
- Assert rst asynchronously mid-CALC (a=100, b=100, after 4 steps) -> busy=0, done=0, p=0 immediately, with no done pulse. After release, a new start with a=100, b=100 gives p=10000.
- Back-to-back: hold start high continuously with a=2, b=9 -> a done pulse every 10 cycles, p=18 each time; add_a=add_b=0 whenever in IDLE or DONE.
